// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared pipeline hazard types: forward-select encoding, result-source constants
// and the bundled stall/flush/forward control word.
package hazard_scoreboard_unit_pkg;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_MC  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic     stall_f;
        logic     stall_d;
        logic     stall_e;
        logic     stall_m;
        logic     flush_d;
        logic     flush_e;
        logic     flush_m;
        logic     flush_w;
        fwd_sel_e forward_a;
        fwd_sel_e forward_b;
    } hazard_ctrl_v2_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit bundle: the pipeline (master) reports stage state,
// the hazard unit (slave) returns stall/flush/forward controls and telemetry.
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int PERF_CNT_W = 32
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic [1:0]            ex_result_src;
    logic                  ex_is_mc;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_reg_write;
    logic [1:0]            mem_result_src;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_reg_write;
    logic                  pc_src_ex;
    logic                  dmem_busy;
    logic                  mc_ready;
    logic                  mc_done;
    logic [REG_ADDR_W-1:0] mc_done_rd;

    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_m;
    logic                  flush_w;
    logic [1:0]            forward_a_e;
    logic [1:0]            forward_b_e;
    logic                  mc_issue;
    logic [NUM_REGS-1:0]   sb_pending;
    logic [PERF_CNT_W-1:0] perf_stall_cycles;
    logic [PERF_CNT_W-1:0] perf_flush_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, id_rd_addr, id_reg_write,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_result_src, ex_is_mc,
        output mem_rd_addr, mem_reg_write, mem_result_src, wb_rd_addr, wb_reg_write,
        output pc_src_ex, dmem_busy, mc_ready, mc_done, mc_done_rd,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
        input  forward_a_e, forward_b_e, mc_issue, sb_pending,
        input  perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, id_rd_addr, id_reg_write,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_result_src, ex_is_mc,
        input  mem_rd_addr, mem_reg_write, mem_result_src, wb_rd_addr, wb_reg_write,
        input  pc_src_ex, dmem_busy, mc_ready, mc_done, mc_done_rd,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
        output forward_a_e, forward_b_e, mc_issue, sb_pending,
        output perf_stall_cycles, perf_flush_count
    );

endinterface

// File: rtl/hazard_scoreboard_unit_mc_scoreboard.sv
// Tracks destination registers of in-flight multi-cycle ops and how many are
// outstanding; completions arrive out of band on a dedicated write port.
module mc_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int NUM_REGS           = 32,
    parameter int MC_MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  done,
    input  logic [REG_ADDR_W-1:0] done_rd,
    output logic [NUM_REGS-1:0]   pending,
    output logic [NUM_REGS-1:0]   pending_eff,
    output logic                  full
);

    localparam int CNT_W = $clog2(MC_MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]    count;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clear_mask;
    logic                done_valid;

    // A completion for a register that is not pending is ignored entirely.
    assign done_valid = done && pending[done_rd];

    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (issue && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (done_valid) begin
            clear_mask[done_rd] = 1'b1;
        end
    end

    // The regfile is write-first, so a register completing this cycle is already readable.
    assign pending_eff = pending & ~clear_mask;
    assign full        = (count == CNT_W'(MC_MAX_OUTSTANDING)) && !done;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | set_mask;
            case ({issue, done_valid})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RV32 pipeline: load-use and multi-cycle scoreboard
// stalls, branch flushes, dmem freeze, EX operand forwarding and perf counters.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int NUM_REGS           = 32,
    parameter int MC_MAX_OUTSTANDING = 2,
    parameter int PERF_CNT_W         = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    hazard_scoreboard_unit_if.slave bus
);

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_eff;
    logic                  mc_full;
    logic                  mc_block;
    logic                  mc_issue;
    logic                  late_raw;
    logic                  sb_raw;
    logic                  sb_waw;
    logic                  mem_fwd_ok;
    hazard_ctrl_v2_t       ctrl;
    logic [PERF_CNT_W-1:0] stall_cycles;
    logic [PERF_CNT_W-1:0] flush_count;

    function automatic fwd_sel_e fwd_pick(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] mc_rd,
        input logic                  mc_done
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (mem_ok && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_we && (wb_rd == rs)) begin
                sel = FWD_WB;
            end else if (mc_done && (mc_rd == rs)) begin
                sel = FWD_MC;
            end
        end
        return sel;
    endfunction

    mc_scoreboard #(
        .REG_ADDR_W        (REG_ADDR_W),
        .NUM_REGS          (NUM_REGS),
        .MC_MAX_OUTSTANDING(MC_MAX_OUTSTANDING)
    ) u_mc_scoreboard (
        .clk        (clk_i),
        .rst        (rst_i),
        .issue      (mc_issue),
        .issue_rd   (bus.ex_rd_addr),
        .done       (bus.mc_done),
        .done_rd    (bus.mc_done_rd),
        .pending    (pending),
        .pending_eff(pending_eff),
        .full       (mc_full)
    );

    assign mc_block = bus.ex_is_mc && (!bus.mc_ready || mc_full);
    assign mc_issue = bus.ex_is_mc && !bus.dmem_busy && !mc_block;

    // Loads and MC ops in EX have no result to forward yet, so ID must wait a cycle.
    assign late_raw = (bus.ex_result_src == RESULT_SRC_MEM || bus.ex_is_mc)
                      && bus.ex_reg_write && (bus.ex_rd_addr != '0)
                      && ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr))
                       || (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));

    assign sb_raw = (bus.id_uses_rs1 && pending_eff[bus.id_rs1_addr])
                 || (bus.id_uses_rs2 && pending_eff[bus.id_rs2_addr]);
    assign sb_waw = bus.id_reg_write && pending_eff[bus.id_rd_addr];

    assign mem_fwd_ok = bus.mem_reg_write && (bus.mem_result_src != RESULT_SRC_MEM);

    always_comb begin
        ctrl           = '0;
        ctrl.forward_a = fwd_pick(bus.ex_rs1_addr, bus.mem_rd_addr, mem_fwd_ok,
                                  bus.wb_rd_addr, bus.wb_reg_write, bus.mc_done_rd, bus.mc_done);
        ctrl.forward_b = fwd_pick(bus.ex_rs2_addr, bus.mem_rd_addr, mem_fwd_ok,
                                  bus.wb_rd_addr, bus.wb_reg_write, bus.mc_done_rd, bus.mc_done);
        // A frozen memory stage outranks everything; a taken branch waits in EX.
        if (bus.dmem_busy) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (bus.pc_src_ex) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (mc_block) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else if (late_raw || sb_raw || sb_waw) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (ctrl.stall_f && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
            end
            if (bus.pc_src_ex && !bus.dmem_busy && (flush_count != '1)) begin
                flush_count <= flush_count + PERF_CNT_W'(1);
            end
        end
    end

    assign bus.stall_f           = ctrl.stall_f;
    assign bus.stall_d           = ctrl.stall_d;
    assign bus.stall_e           = ctrl.stall_e;
    assign bus.stall_m           = ctrl.stall_m;
    assign bus.flush_d           = ctrl.flush_d;
    assign bus.flush_e           = ctrl.flush_e;
    assign bus.flush_m           = ctrl.flush_m;
    assign bus.flush_w           = ctrl.flush_w;
    assign bus.forward_a_e       = ctrl.forward_a;
    assign bus.forward_b_e       = ctrl.forward_b;
    assign bus.mc_issue          = mc_issue;
    assign bus.sb_pending        = pending;
    assign bus.perf_stall_cycles = stall_cycles;
    assign bus.perf_flush_count  = flush_count;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: forwarding, load-use, MC scoreboard,
// issue throttling, dmem freeze with pending branch, and mid-run reset.
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .NUM_REGS(32), .PERF_CNT_W(32)) bus ();

    hazard_scoreboard_unit #(
        .REG_ADDR_W        (5),
        .NUM_REGS          (32),
        .MC_MAX_OUTSTANDING(2),
        .PERF_CNT_W        (32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Control word order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w.
    task automatic checkCtrl(input string tag, input logic [7:0] expected);
        checkOutput(tag, {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                          bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w}, expected);
    endtask

    task automatic idleInputs();
        bus.id_rs1_addr    = '0;
        bus.id_rs2_addr    = '0;
        bus.id_uses_rs1    = 1'b0;
        bus.id_uses_rs2    = 1'b0;
        bus.id_rd_addr     = '0;
        bus.id_reg_write   = 1'b0;
        bus.ex_rs1_addr    = '0;
        bus.ex_rs2_addr    = '0;
        bus.ex_rd_addr     = '0;
        bus.ex_reg_write   = 1'b0;
        bus.ex_result_src  = 2'b00;
        bus.ex_is_mc       = 1'b0;
        bus.mem_rd_addr    = '0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_result_src = 2'b00;
        bus.wb_rd_addr     = '0;
        bus.wb_reg_write   = 1'b0;
        bus.pc_src_ex      = 1'b0;
        bus.dmem_busy      = 1'b0;
        bus.mc_ready       = 1'b0;
        bus.mc_done        = 1'b0;
        bus.mc_done_rd     = '0;
    endtask

    // Carries the currently driven vector across one rising edge.
    task automatic applyStimulus();
        if (bus.mc_done) begin
            checkOutput("done_targets_pending", {63'd0, bus.sb_pending[bus.mc_done_rd]}, 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic driveMcIssue(input logic [4:0] rd);
        bus.ex_is_mc     = 1'b1;
        bus.ex_rd_addr   = rd;
        bus.ex_reg_write = 1'b1;
        bus.mc_ready     = 1'b1;
    endtask

    initial begin
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_pending", bus.sb_pending, 0);
        checkOutput("reset_perf_stall", bus.perf_stall_cycles, 0);
        checkOutput("reset_perf_flush", bus.perf_flush_count, 0);
        checkCtrl("reset_ctrl", 8'b0000_0000);

        // Forwarding from MEM, WB, and the load-in-MEM / x0 boundaries.
        bus.mem_rd_addr = 5'd5; bus.mem_reg_write = 1'b1; bus.ex_rs1_addr = 5'd5;
        #1;
        checkOutput("fwd_a_mem", bus.forward_a_e, 2'b10);
        checkOutput("fwd_b_none", bus.forward_b_e, 2'b00);
        bus.mem_reg_write = 1'b0; bus.wb_rd_addr = 5'd5; bus.wb_reg_write = 1'b1;
        #1;
        checkOutput("fwd_a_wb", bus.forward_a_e, 2'b01);
        bus.mem_reg_write = 1'b1; bus.mem_result_src = 2'b01; bus.ex_rs2_addr = 5'd5;
        #1;
        checkOutput("fwd_b_load_in_mem_uses_wb", bus.forward_b_e, 2'b01);
        idleInputs();
        bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        #1;
        checkOutput("fwd_x0_never", bus.forward_a_e, 2'b00);
        applyStimulus();

        // Load-use on rs2, then the same pair with rs2 unused.
        idleInputs();
        bus.ex_rd_addr = 5'd6; bus.ex_reg_write = 1'b1; bus.ex_result_src = 2'b01;
        bus.id_rs2_addr = 5'd6; bus.id_uses_rs2 = 1'b1;
        #1;
        checkCtrl("load_use_stall", 8'b1100_0100);
        applyStimulus();
        bus.id_uses_rs2 = 1'b0;
        #1;
        checkCtrl("load_unused_src", 8'b0000_0000);
        applyStimulus();
        checkOutput("perf_stall_after_load_use", bus.perf_stall_cycles, 1);

        // DIV x7 issues while ID already reads x7, then waits on the scoreboard.
        idleInputs();
        driveMcIssue(5'd7);
        bus.id_rs1_addr = 5'd7; bus.id_uses_rs1 = 1'b1;
        #1;
        checkOutput("div_issue", bus.mc_issue, 1);
        checkCtrl("div_issue_cycle_late_raw", 8'b1100_0100);
        applyStimulus();
        bus.ex_is_mc = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd_addr = '0;
        #1;
        checkOutput("div_pending_x7", bus.sb_pending, 32'h0000_0080);
        checkCtrl("sb_raw_stall", 8'b1100_0100);
        applyStimulus();
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd7; bus.ex_rs1_addr = 5'd7;
        #1;
        checkCtrl("sb_raw_released_by_done", 8'b0000_0000);
        checkOutput("fwd_a_mc", bus.forward_a_e, 2'b11);
        applyStimulus();
        checkOutput("div_cleared", bus.sb_pending, 0);
        checkOutput("perf_stall_after_div", bus.perf_stall_cycles, 3);

        // Fill both MC slots, then throttle a third issue.
        idleInputs();
        driveMcIssue(5'd8);
        applyStimulus();
        driveMcIssue(5'd9);
        applyStimulus();
        driveMcIssue(5'd10);
        #1;
        checkOutput("two_in_flight", bus.sb_pending, 32'h0000_0300);
        checkCtrl("mc_full_block", 8'b1110_0010);
        checkOutput("mc_full_no_issue", bus.mc_issue, 0);
        applyStimulus();
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd8;
        #1;
        checkCtrl("mc_full_freed_by_done", 8'b0000_0000);
        checkOutput("mc_issue_same_cycle_done", bus.mc_issue, 1);
        applyStimulus();
        checkOutput("slot_swapped", bus.sb_pending, 32'h0000_0600);

        // WAW against pending x9, and its release by a same-cycle completion.
        idleInputs();
        bus.id_rd_addr = 5'd9; bus.id_reg_write = 1'b1;
        #1;
        checkCtrl("sb_waw_stall", 8'b1100_0100);
        applyStimulus();
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd9;
        #1;
        checkCtrl("sb_waw_cleared", 8'b0000_0000);
        applyStimulus();

        // MC unit not ready with a free slot still blocks.
        idleInputs();
        driveMcIssue(5'd11);
        bus.mc_ready = 1'b0;
        #1;
        checkCtrl("mc_not_ready_block", 8'b1110_0010);
        checkOutput("mc_not_ready_no_issue", bus.mc_issue, 0);
        applyStimulus();

        // Data memory freeze holds a taken branch until release.
        idleInputs();
        bus.dmem_busy = 1'b1; bus.pc_src_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCtrl("dmem_freeze", 8'b1111_0001);
            applyStimulus();
        end
        bus.dmem_busy = 1'b0;
        #1;
        checkCtrl("branch_after_release", 8'b0000_1100);
        applyStimulus();
        bus.pc_src_ex = 1'b0;
        #1;
        checkOutput("perf_flush_once", bus.perf_flush_count, 1);
        checkOutput("perf_stall_total", bus.perf_stall_cycles, 9);

        // Reset with two ops outstanding, then a fresh issue must be accepted.
        driveMcIssue(5'd12);
        applyStimulus();
        idleInputs();
        #1;
        checkOutput("pending_before_reset", bus.sb_pending, 32'h0000_1400);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("reset_mid_pending", bus.sb_pending, 0);
        checkOutput("reset_mid_perf_stall", bus.perf_stall_cycles, 0);
        checkOutput("reset_mid_perf_flush", bus.perf_flush_count, 0);
        driveMcIssue(5'd13);
        #1;
        checkOutput("issue_after_reset", bus.mc_issue, 1);
        applyStimulus();
        checkOutput("pending_after_reset_issue", bus.sb_pending, 32'h0000_2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised next-generation hazard unit for the 5-stage RV32 pipeline. It keeps the existing load-use, branch-flush and EX-operand forwarding duties. It adds a registered scoreboard for long-latency multi-cycle (MC) ops such as DIV/REM, which complete out of band through a dedicated regfile write port. It also adds a data-memory-busy freeze, source-use qualification to avoid false stalls, and saturating performance counters. It sits beside the pipeline registers and drives all stall, flush and forward selects.

Parameters:
REG_ADDR_W, 5, register address width
NUM_REGS, 32, architectural registers tracked by the scoreboard
MC_MAX_OUTSTANDING, 2, max in-flight MC ops (1..4)
PERF_CNT_W, 32, width of each perf counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs1_addr_i / id_rs2_addr_i  in  REG_ADDR_W  ID sources
id_uses_rs1_i / id_uses_rs2_i  in  1  ID instr actually reads rs1/rs2
id_rd_addr_i  in  REG_ADDR_W  ID destination
id_reg_write_i  in  1  ID writes rd
ex_rs1_addr_i / ex_rs2_addr_i / ex_rd_addr_i  in  REG_ADDR_W  EX operands
ex_reg_write_i  in  1  EX writes rd
ex_result_src_i  in  2  EX result source (2'b01 = load)
ex_is_mc_i  in  1  EX holds an MC op (0 for bubbles)
mem_rd_addr_i  in  REG_ADDR_W  MEM destination
mem_reg_write_i  in  1  MEM writes rd
mem_result_src_i  in  2  MEM result source
wb_rd_addr_i  in  REG_ADDR_W  WB destination
wb_reg_write_i  in  1  WB writes rd
pc_src_ex_i  in  1  branch/jump taken in EX
dmem_busy_i  in  1  data memory not ready
mc_ready_i  in  1  MC unit accepts an issue
mc_done_i  in  1  MC result written this cycle
mc_done_rd_i  in  REG_ADDR_W  MC result destination
stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1  hold PC / IF-ID / ID-EX / EX-MEM
flush_d_o, flush_e_o, flush_m_o, flush_w_o  out  1  bubble into ID / EX / MEM / WB
forward_a_e_o, forward_b_e_o  out  2  00 regfile, 10 EX/MEM ALU, 01 MEM/WB result, 11 MC result
mc_issue_o  out  1  MC op handed to unit this cycle
sb_pending_o  out  NUM_REGS  scoreboard bits
perf_stall_cycles_o  out  PERF_CNT_W  cycles with stall_f_o=1
perf_flush_count_o  out  PERF_CNT_W  branch flush events

Behaviour:
- Reset (sync, rst_i=1 at edge): scoreboard=0, outstanding count=0, both perf counters=0. Combinational outputs follow their inputs. Reset mid-operation discards all pending bits. The MC unit shares rst_i.
- x0 is never pending and never a hazard or forward source.
- mc_full = (count==MC_MAX_OUTSTANDING) && !mc_done_i. A same-cycle completion frees a slot.
- mc_block = ex_is_mc_i && (!mc_ready_i || mc_full).
- late_raw: EX instr is a load or MC op, ex_reg_write_i=1, ex_rd!=0, and ex_rd equals a used ID source.
- sb_raw: a used ID source has pending[rs]=1 and is not cleared by mc_done_i this cycle. The regfile is write-first, so a same-cycle MC write is visible to ID.
- sb_waw: id_reg_write_i=1 and pending[id_rd]=1 and it is not cleared this cycle.
- Priority (first match wins; all unlisted outputs 0):
  1. dmem_busy_i: stall_f/d/e/m=1, flush_w=1; mc_issue_o=0. A taken branch stays in EX and flushes after release.
  2. pc_src_ex_i: flush_d=1, flush_e=1.
  3. mc_block: stall_f/d/e=1, flush_m=1.
  4. late_raw or sb_raw or sb_waw: stall_f/d=1, flush_e=1.
- mc_issue_o = ex_is_mc_i && !dmem_busy_i && !mc_block.
- Scoreboard update at the edge: issue sets pending[ex_rd] (when rd!=0) and increments count; mc_done_i clears pending[mc_done_rd_i] and decrements count. Simultaneous issue and done leaves count unchanged, and both bit updates apply (they are different registers because WAW is stalled).
- mc_done_i with its bit already clear is a protocol error: bit and count unchanged, and the bench asserts.
- Forwarding per operand, priority: MEM (reg_write, rd match, result_src!=01) gives 10; else WB match gives 01; else mc_done_i with rd match gives 11; else 00. Forwarding is evaluated every cycle, independent of stalls.
- perf_stall_cycles_o increments when stall_f_o=1. perf_flush_count_o increments when pc_src_ex_i=1 and dmem_busy_i=0. Both saturate at all-ones.
- Latency: scoreboard state becomes visible one cycle after issue. late_raw covers the issue cycle itself.

Decomposition:
- Package additions to the pipeline types header: fwd_sel_e enum {FWD_RF, FWD_MEM, FWD_WB, FWD_MC}, RESULT_SRC_MEM constant 2'b01, and a hazard_ctrl_v2_t struct bundling the stall/flush/forward outputs.
- One sub-module, mc_scoreboard: pending vector, outstanding counter, full/clear logic.

Test Plan:
- ADD x5 in MEM, EX reads rs1=x5 -> forward_a_e_o=10. The same ADD in WB instead -> 01.
- LW x6 in EX, ID reads rs2=x6 with id_uses_rs2_i=1 -> stall_f/d=1, flush_e=1 for 1 cycle. With id_uses_rs2_i=0 -> no stall.
- DIV x7 issue (mc_ready_i=1) -> sb_pending_o[7]=1 next cycle. A dependent ID instr stalls until mc_done_i with rd=7; that cycle the stall drops, and an EX use of x7 gets 11.
- MC_MAX_OUTSTANDING=2 with two ops in flight, third MC op in EX, mc_ready_i=1 -> stall_f/d/e=1, flush_m=1. mc_done_i in the same cycle -> issue proceeds.
- dmem_busy_i=1 for 3 cycles while pc_src_ex_i=1 -> stall_f/d/e/m=1, flush_w=1, no flush_d. After release, flush_d/e=1 and perf_flush_count_o increments by exactly 1.
- Assert rst_i with 2 ops pending -> next cycle sb_pending_o=0, counters=0, and a new issue is accepted.
